// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: synchronises raw requests, latches edge/level events into
// PEND, gates them with MASK and GIE, and exposes a lowest-index-first ID register.
module int_ctrl #(
  parameter int unsigned N_SRC       = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic [N_SRC-1:0] int_out,
  output logic             int_any
);

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_chain_q;
  logic [N_SRC-1:0] sync_q, prev_q;
  logic             gie_q, gie_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] rise;
  logic [2:0]       reg_sel;
  logic             pend_w1c;
  logic [3:0]       id_idx;
  logic             unused_bits;

  assign sync_q      = sync_chain_q[SYNC_STAGES-1];
  assign rise        = sync_q & ~prev_q;
  assign reg_sel     = Addr[4:2];
  assign pend_w1c    = WE && (reg_sel == 3'd3);
  assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

  always_comb begin
    gie_d  = gie_q;
    mask_d = mask_q;
    mode_d = mode_q;
    if (WE) begin
      case (reg_sel)
        3'd0:    gie_d  = Din[0];
        3'd1:    mask_d = Din[N_SRC-1:0];
        3'd2:    mode_d = Din[N_SRC-1:0];
        default: ;
      endcase
    end
  end

  // Edge-mode set takes priority over a simultaneous W1C so no event is lost.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        if (rise[i])                    pend_d[i] = 1'b1;
        else if (pend_w1c && Din[i])    pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = sync_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_chain_q <= '0;
      prev_q       <= '0;
      gie_q        <= 1'b0;
      mask_q       <= '0;
      mode_q       <= '0;
      pend_q       <= '0;
    end else begin
      sync_chain_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_chain_q[s] <= sync_chain_q[s-1];
      prev_q <= sync_q;
      gie_q  <= gie_d;
      mask_q <= mask_d;
      mode_q <= mode_d;
      pend_q <= pend_d;
    end
  end

  assign int_out = pend_q & mask_q & {N_SRC{gie_q}};
  assign int_any = |int_out;

  always_comb begin
    id_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (int_out[i]) id_idx = 4'(i);
    end
  end

  always_comb begin
    Dout = '0;
    case (reg_sel)
      3'd0:    Dout = {31'b0, gie_q};
      3'd1:    Dout = 32'(mask_q);
      3'd2:    Dout = 32'(mode_q);
      3'd3:    Dout = 32'(pend_q);
      3'd4:    Dout = {int_any, 27'b0, id_idx};
      3'd5:    Dout = 32'(sync_q);
      default: Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a queue scoreboard of expected values.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [5:0]  irq_in;
  logic [5:0]  int_out;
  logic        int_any;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  int_ctrl #(.N_SRC(6), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .irq_in  (irq_in),
    .int_out (int_out),
    .int_any (int_any)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    push(tag, e);
    pop_chk(obs);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = {27'b0, a};
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    Addr = {27'b0, a};
    #1 d = Dout;
  endtask

  logic [31:0] r;

  initial begin
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0; irq_in = 6'h3F;

    // 1: reset state with all sources asserted in level mode
    repeat (2) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), r);
      chk($sformatf("reset_reg%0d", a), r, 32'h0);
    end
    chk("reset_int_out", {26'b0, int_out}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("lvl_masked_int_out", {26'b0, int_out}, 32'h0);
    rd(3'd3, r); chk("lvl_pend_all", r, 32'h3F);
    rd(3'd5, r); chk("raw_all", r, 32'h3F);
    irq_in = 6'h00;
    repeat (3) @(negedge clk);
    rd(3'd3, r); chk("lvl_pend_clear", r, 32'h0);

    // 2: edge latch on source 2
    wr(3'd2, 32'h04);
    wr(3'd1, 32'h04);
    wr(3'd0, 32'h01);
    irq_in[2] = 1'b1;
    push("edge_n1", 32'h00); push("edge_n2", 32'h00);
    push("edge_n3", 32'h04); push("edge_n4", 32'h04);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) irq_in[2] = 1'b0;
      pop_chk({26'b0, int_out});
    end
    rd(3'd4, r); chk("edge_id", r, 32'h8000_0002);
    wr(3'd3, 32'h04);
    chk("edge_w1c_int_out", {26'b0, int_out}, 32'h0);

    // 3: set and W1C of source 1 on the same edge
    wr(3'd2, 32'h06);
    irq_in[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Addr = 30'd3; Din = 32'h02; WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
    rd(3'd3, r); chk("collision_set_wins", r, 32'h02);
    wr(3'd3, 32'h02);
    rd(3'd3, r); chk("w1c_after_collision", r, 32'h00);
    irq_in[1] = 1'b0;

    // 4: level mode follows input, W1C ignored
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h01);
    irq_in[0] = 1'b1;
    for (int j = 1; j <= 8; j++) push($sformatf("level_n%0d", j), (j >= 3 && j <= 7) ? 32'h1 : 32'h0);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      pop_chk({26'b0, int_out});
      if (j == 5) irq_in[0] = 1'b0;
      Addr = 30'd3; Din = 32'h01; WE = (j == 3);
    end
    WE = 1'b0;

    // 5: priority and mask/GIE gating
    wr(3'd2, 32'h1A);
    wr(3'd1, 32'h18);
    irq_in = 6'h1A;
    @(negedge clk);
    irq_in = 6'h00;
    repeat (3) @(negedge clk);
    chk("prio_int_out", {26'b0, int_out}, 32'h18);
    rd(3'd4, r); chk("prio_id", r, 32'h8000_0003);
    wr(3'd0, 32'h00);
    chk("gie_off_int_out", {26'b0, int_out}, 32'h0);
    chk("gie_off_int_any", {31'b0, int_any}, 32'h0);
    rd(3'd3, r); chk("gie_off_pend", r, 32'h1A);
    wr(3'd0, 32'h01);
    chk("gie_on_int_out", {26'b0, int_out}, 32'h18);

    // 6: async reset between edges
    wr(3'd2, 32'h3F);
    wr(3'd1, 32'h3F);
    irq_in = 6'h3F;
    @(negedge clk);
    irq_in = 6'h00;
    repeat (3) @(negedge clk);
    chk("pre_reset_int_out", {26'b0, int_out}, 32'h3F);
    chk("pre_reset_int_any", {31'b0, int_any}, 32'h1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_int_out", {26'b0, int_out}, 32'h0);
    chk("async_reset_int_any", {31'b0, int_any}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd3, r); chk("post_reset_pend", r, 32'h0);
    rd(3'd1, r); chk("post_reset_mask", r, 32'h0);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
